// File: rtl/dot_stream_accum_if.sv
// Beat/frame bus of the streaming dot-product engine.
// The master drives beats; the slave publishes completed frames.
interface dot_stream_accum_if #(
  parameter int BIT_LENGTH = 16,
  parameter int DATA_N     = 6,
  parameter int HID_LENGTH = 24
);
  logic                             run;
  logic [DATA_N*BIT_LENGTH-1:0]     data_in;
  logic [DATA_N*BIT_LENGTH-1:0]     weight_in;
  logic                             valid;
  logic                             busy;
  logic [HID_LENGTH*BIT_LENGTH-1:0] data_out;

  modport master (output run, data_in, weight_in, input valid, busy, data_out);
  modport slave  (input run, data_in, weight_in, output valid, busy, data_out);
endinterface

// File: rtl/dot_stream_accum.sv
// Streaming dot-product engine: multiply -> tree/accumulate -> scale/saturate,
// collecting HID_LENGTH outputs per frame and publishing them on a held bus.
module dot_stream_accum #(
  parameter int BIT_LENGTH = 16,
  parameter int DATA_N     = 6,
  parameter int HID_LENGTH = 24,
  parameter int CHUNKS     = 1,
  parameter int FRAC       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  dot_stream_accum_if.slave  bus
);
  localparam int PROD_W = 2 * BIT_LENGTH;
  localparam int ACC_W  = PROD_W + $clog2(DATA_N * CHUNKS) + 1;
  localparam int BEAT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int HID_W  = (HID_LENGTH > 1) ? $clog2(HID_LENGTH) : 1;

  logic signed [PROD_W-1:0]     w_prod [DATA_N];
  logic signed [PROD_W-1:0]     r_prod [DATA_N];
  logic                         r_s1_vld, r_s1_first, r_s1_last;
  logic [HID_W-1:0]             r_s1_hid;
  logic signed [ACC_W-1:0]      w_tree, r_acc, w_scaled;
  logic                         r_s2_vld;
  logic [HID_W-1:0]             r_s2_hid;
  logic [BEAT_W-1:0]            r_beat_cnt, w_beat_cnt_nx;
  logic [HID_W-1:0]             r_hid_cnt, w_hid_cnt_nx;
  logic                         w_beat_last, w_hid_last;
  logic [ACC_W-BIT_LENGTH:0]    w_top;
  logic                         w_in_range, w_publish, w_busy_nx;
  logic signed [BIT_LENGTH-1:0] w_sat;
  logic signed [BIT_LENGTH-1:0] r_buf [HID_LENGTH];
  logic signed [BIT_LENGTH-1:0] r_out [HID_LENGTH];
  logic                         r_valid, r_busy;

  // Operands are sign-extended to full product width so the multiply is exact.
  for (genvar gi = 0; gi < DATA_N; gi++) begin : g_lane
    logic [BIT_LENGTH-1:0]    w_d_raw, w_w_raw;
    logic signed [PROD_W-1:0] w_d, w_w;
    assign w_d_raw    = bus.data_in[gi*BIT_LENGTH +: BIT_LENGTH];
    assign w_w_raw    = bus.weight_in[gi*BIT_LENGTH +: BIT_LENGTH];
    assign w_d        = {{BIT_LENGTH{w_d_raw[BIT_LENGTH-1]}}, w_d_raw};
    assign w_w        = {{BIT_LENGTH{w_w_raw[BIT_LENGTH-1]}}, w_w_raw};
    assign w_prod[gi] = w_d * w_w;
  end

  assign w_beat_last = (r_beat_cnt == BEAT_W'(CHUNKS - 1));
  assign w_hid_last  = (r_hid_cnt == HID_W'(HID_LENGTH - 1));

  always_comb begin
    w_beat_cnt_nx = r_beat_cnt;
    w_hid_cnt_nx  = r_hid_cnt;
    if (bus.run) begin
      if (w_beat_last) begin
        w_beat_cnt_nx = '0;
        w_hid_cnt_nx  = w_hid_last ? '0 : r_hid_cnt + 1'b1;
      end else begin
        w_beat_cnt_nx = r_beat_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_hid_cnt  <= '0;
    end else begin
      r_beat_cnt <= w_beat_cnt_nx;
      r_hid_cnt  <= w_hid_cnt_nx;
    end
  end

  // Stage 1: products only load on accepted beats so idle lanes never enter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_N; i++) r_prod[i] <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_hid   <= '0;
    end else begin
      r_s1_vld <= bus.run;
      if (bus.run) begin
        for (int i = 0; i < DATA_N; i++) r_prod[i] <= w_prod[i];
        r_s1_first <= (r_beat_cnt == '0);
        r_s1_last  <= w_beat_last;
        r_s1_hid   <= r_hid_cnt;
      end
    end
  end

  always_comb begin
    w_tree = '0;
    for (int i = 0; i < DATA_N; i++)
      w_tree = w_tree + {{(ACC_W-PROD_W){r_prod[i][PROD_W-1]}}, r_prod[i]};
  end

  // Stage 2: the first chunk of an output reloads, later chunks accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_s2_vld <= 1'b0;
      r_s2_hid <= '0;
    end else begin
      r_s2_vld <= r_s1_vld & r_s1_last;
      if (r_s1_vld) begin
        r_acc    <= r_s1_first ? w_tree : r_acc + w_tree;
        r_s2_hid <= r_s1_hid;
      end
    end
  end

  if (FRAC > 0) begin : g_round
    logic signed [ACC_W-1:0] w_rounded;
    assign w_rounded = r_acc + (ACC_W'(1) << (FRAC - 1));
    assign w_scaled  = w_rounded >>> FRAC;
  end else begin : g_noround
    assign w_scaled = r_acc;
  end

  // In range iff every bit from the output sign bit upward agrees.
  assign w_top      = w_scaled[ACC_W-1:BIT_LENGTH-1];
  assign w_in_range = (&w_top) | ~(|w_top);
  assign w_sat      = w_in_range ? w_scaled[BIT_LENGTH-1:0] :
                      (w_scaled[ACC_W-1] ? {1'b1, {(BIT_LENGTH-1){1'b0}}}
                                         : {1'b0, {(BIT_LENGTH-1){1'b1}}});

  assign w_publish = r_s2_vld && (r_s2_hid == HID_W'(HID_LENGTH - 1));
  assign w_busy_nx = bus.run || (w_beat_cnt_nx != '0) || (w_hid_cnt_nx != '0) ||
                     r_s1_vld || (r_s2_vld && !w_publish);

  // Stage 3: the last slot bypasses the working buffer straight into the published copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < HID_LENGTH; h++) begin
        r_buf[h] <= '0;
        r_out[h] <= '0;
      end
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= w_publish;
      r_busy  <= w_busy_nx;
      for (int h = 0; h < HID_LENGTH; h++) begin
        if (r_s2_vld && (r_s2_hid == HID_W'(h)))
          r_buf[h] <= w_sat;
        if (w_publish)
          r_out[h] <= (h == HID_LENGTH - 1) ? w_sat : r_buf[h];
      end
    end
  end

  for (genvar gi = 0; gi < HID_LENGTH; gi++) begin : g_out
    assign bus.data_out[gi*BIT_LENGTH +: BIT_LENGTH] = r_out[gi];
  end
  assign bus.valid = r_valid;
  assign bus.busy  = r_busy;
endmodule

// File: tb/tb_dot_stream_accum.sv
// Directed bench for dot_stream_accum: defaults, FRAC=8 and CHUNKS=2 instances
// sharing one clock and reset, each scenario checked inline against hand values.
module tb_dot_stream_accum;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dot_stream_accum_if #(.BIT_LENGTH(16), .DATA_N(6), .HID_LENGTH(24)) if_def ();
  dot_stream_accum_if #(.BIT_LENGTH(16), .DATA_N(6), .HID_LENGTH(24)) if_frac ();
  dot_stream_accum_if #(.BIT_LENGTH(16), .DATA_N(6), .HID_LENGTH(24)) if_chk ();

  dot_stream_accum u_def (.clk(clk), .rst_n(rst_n), .bus(if_def.slave));
  dot_stream_accum #(.FRAC(8)) u_frac (.clk(clk), .rst_n(rst_n), .bus(if_frac.slave));
  dot_stream_accum #(.CHUNKS(2)) u_chk (.clk(clk), .rst_n(rst_n), .bus(if_chk.slave));

  function automatic logic [95:0] pack6(input int a0, a1, a2, a3, a4, a5);
    logic [95:0] v;
    v = {a5[15:0], a4[15:0], a3[15:0], a2[15:0], a1[15:0], a0[15:0]};
    return v;
  endfunction

  // Inputs are applied at a falling edge and held over the following rising edge.
  task automatic drive(input int which, input logic r, input logic [95:0] d, input logic [95:0] w);
    if_def.run        = (which == 0) ? r : 1'b0;
    if_def.data_in    = (which == 0) ? d : '0;
    if_def.weight_in  = (which == 0) ? w : '0;
    if_frac.run       = (which == 1) ? r : 1'b0;
    if_frac.data_in   = (which == 1) ? d : '0;
    if_frac.weight_in = (which == 1) ? w : '0;
    if_chk.run        = (which == 2) ? r : 1'b0;
    if_chk.data_in    = (which == 2) ? d : '0;
    if_chk.weight_in  = (which == 2) ? w : '0;
    @(negedge clk);
  endtask

  task automatic idle(input int which);
    drive(which, 1'b0, 'x, 'x);
  endtask

  // 24 beats (only beats 0 and 23 non-zero) then two idles: returns in the publish cycle.
  task automatic frame(input int which, input logic [95:0] d0, w0, d23, w23);
    for (int b = 0; b < 24; b++)
      drive(which, 1'b1, (b == 0) ? d0 : ((b == 23) ? d23 : '0),
                         (b == 0) ? w0 : ((b == 23) ? w23 : '0));
    idle(which);
    idle(which);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(3, 1'b0, '0, '0);
    checks++; if (if_def.data_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", if_def.data_out); end
    checks++; if (if_def.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_def.valid); end
    checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if_def.busy); end
    checks++; if (if_chk.busy !== 1'b0) begin errors++; $display("FAIL reset_chk_busy: got %b expected 0", if_chk.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    logic signed [15:0] got;
    for (int b = 0; b < 24; b++) begin
      drive(0, 1'b1, (b == 0) ? pack6(-9, -8, -5, -1, -5, -3) : '0,
                     (b == 0) ? pack6(5, 3, 2, 9, 5, 2) : '0);
      if (b == 0) begin
        checks++; if (if_def.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b expected 1", if_def.busy); end
      end
    end
    checks++; if (if_def.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_t1: got %b expected 0", if_def.valid); end
    idle(0);
    checks++; if (if_def.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_t2: got %b expected 0", if_def.valid); end
    idle(0);
    got = if_def.data_out[15:0];
    checks++; if (if_def.valid !== 1'b1) begin errors++; $display("FAIL basic_valid_t3: got %b expected 1", if_def.valid); end
    checks++; if (got !== -16'sd119) begin errors++; $display("FAIL basic_slot0: got %0d expected -119", got); end
    checks++; if (if_def.data_out[383:16] !== '0) begin errors++; $display("FAIL basic_slots_rest: got %h expected 0", if_def.data_out[383:16]); end
    checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b expected 0", if_def.busy); end
    idle(0);
    got = if_def.data_out[15:0];
    checks++; if (if_def.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_t4: got %b expected 0", if_def.valid); end
    checks++; if (got !== -16'sd119) begin errors++; $display("FAIL basic_hold: got %0d expected -119", got); end
    $display("basic frame slot0=%0d", got);
  endtask

  task automatic test_saturation();
    logic signed [15:0] got;
    frame(0, pack6(32767, 32767, 32767, 32767, 32767, 32767),
             pack6(32767, 32767, 32767, 32767, 32767, 32767), '0, '0);
    got = if_def.data_out[15:0];
    checks++; if (if_def.valid !== 1'b1) begin errors++; $display("FAIL sat_pos_valid: got %b expected 1", if_def.valid); end
    checks++; if (got !== 16'sd32767) begin errors++; $display("FAIL sat_pos: got %0d expected 32767", got); end
    $display("saturation positive slot0=%0d", got);
    idle(0);
    frame(0, pack6(-32768, -32768, -32768, -32768, -32768, -32768),
             pack6(32767, 32767, 32767, 32767, 32767, 32767), '0, '0);
    got = if_def.data_out[15:0];
    checks++; if (if_def.valid !== 1'b1) begin errors++; $display("FAIL sat_neg_valid: got %b expected 1", if_def.valid); end
    checks++; if (got !== -16'sd32768) begin errors++; $display("FAIL sat_neg: got %0d expected -32768", got); end
    $display("saturation negative slot0=%0d", got);
    idle(0);
  endtask

  task automatic test_rounding();
    int d_tab[4] = '{384, 1, -1, -1};
    int w_tab[4] = '{384, 128, 128, 129};
    int e_tab[4] = '{576, 1, 0, -1};
    logic signed [15:0] got;
    for (int k = 0; k < 4; k++) begin
      frame(1, pack6(d_tab[k], 0, 0, 0, 0, 0), pack6(w_tab[k], 0, 0, 0, 0, 0), '0, '0);
      got = if_frac.data_out[15:0];
      checks++; if (if_frac.valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d]: got %b expected 1", k, if_frac.valid); end
      checks++; if (got !== 16'(e_tab[k])) begin errors++; $display("FAIL round[%0d]: got %0d expected %0d", k, got, e_tab[k]); end
      $display("rounding %0d*%0d -> %0d", d_tab[k], w_tab[k], got);
      idle(1);
    end
  endtask

  // 48-beat CHUNKS=2 frame; beat b has dot product 3*(b+1) - b, so slot h = 8h+8.
  task automatic chk_frame(input int stall, output int vcnt);
    int cnt;
    cnt  = 0;
    vcnt = -1;
    for (int b = 0; b < 48; b++) begin
      if (b == 6) begin
        for (int s = 0; s < stall; s++) begin
          idle(2);
          cnt++;
          if (if_chk.valid && vcnt < 0) vcnt = cnt;
          if (s == 0) begin
            checks++; if (if_chk.busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b expected 1", if_chk.busy); end
          end
        end
      end
      drive(2, 1'b1, pack6(b + 1, 0, 0, 0, 0, -1), pack6(3, 0, 0, 0, 0, b));
      cnt++;
      if (if_chk.valid && vcnt < 0) vcnt = cnt;
    end
    for (int k = 0; k < 10 && vcnt < 0; k++) begin
      idle(2);
      cnt++;
      if (if_chk.valid) vcnt = cnt;
    end
  endtask

  task automatic test_stall_chunks();
    int vcnt;
    logic [383:0] snap;
    logic signed [15:0] got;
    chk_frame(0, vcnt);
    checks++; if (vcnt !== 50) begin errors++; $display("FAIL chunks_latency: got %0d expected 50", vcnt); end
    for (int h = 0; h < 24; h++) begin
      got = if_chk.data_out[h*16 +: 16];
      checks++; if (got !== 16'(8*h + 8)) begin errors++; $display("FAIL chunks_slot[%0d]: got %0d expected %0d", h, got, 8*h + 8); end
    end
    $display("chunks frame valid at cycle %0d", vcnt);
    snap = if_chk.data_out;
    idle(2);
    chk_frame(3, vcnt);
    checks++; if (vcnt !== 53) begin errors++; $display("FAIL stall_latency: got %0d expected 53", vcnt); end
    checks++; if (if_chk.data_out !== snap) begin errors++; $display("FAIL stall_data: got %h expected %h", if_chk.data_out, snap); end
    $display("stalled frame valid at cycle %0d", vcnt);
    idle(2);
  endtask

  task automatic test_back_to_back();
    int p1, p2, npulse;
    logic [95:0] d, w;
    logic signed [15:0] s0, s23;
    p1 = -1; p2 = -1; npulse = 0;
    for (int s = 0; s < 50; s++) begin
      d = (s == 0) ? pack6(3, 0, 0, 0, 0, 0) : (s == 24) ? pack6(-7, 0, 0, 0, 0, 0) :
          (s == 47) ? pack6(0, 100, 0, 0, 0, 0) : '0;
      w = (s == 0) ? pack6(4, 0, 0, 0, 0, 0) : (s == 24) ? pack6(6, 0, 0, 0, 0, 0) :
          (s == 47) ? pack6(0, -2, 0, 0, 0, 0) : '0;
      if (s < 48) drive(0, 1'b1, d, w);
      else        idle(0);
      s0  = if_def.data_out[15:0];
      s23 = if_def.data_out[383:368];
      if (if_def.valid) begin
        npulse++;
        if (p1 < 0) p1 = s + 1;
        else        p2 = s + 1;
      end
      if (s + 1 == 26) begin
        checks++; if (if_def.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_overlap: got %b expected 1", if_def.busy); end
      end
      if (s + 1 == 40 || s + 1 == 49) begin
        checks++; if (s0 !== 16'sd12) begin errors++; $display("FAIL b2b_hold_slot0@%0d: got %0d expected 12", s + 1, s0); end
        checks++; if (s23 !== 16'sd0) begin errors++; $display("FAIL b2b_hold_slot23@%0d: got %0d expected 0", s + 1, s23); end
      end
    end
    checks++; if (p1 !== 26) begin errors++; $display("FAIL b2b_pulse1: got %0d expected 26", p1); end
    checks++; if (p2 !== 50) begin errors++; $display("FAIL b2b_pulse2: got %0d expected 50", p2); end
    checks++; if (npulse !== 2) begin errors++; $display("FAIL b2b_npulse: got %0d expected 2", npulse); end
    checks++; if (s0 !== -16'sd42) begin errors++; $display("FAIL b2b_slot0: got %0d expected -42", s0); end
    checks++; if (s23 !== -16'sd200) begin errors++; $display("FAIL b2b_slot23: got %0d expected -200", s23); end
    checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", if_def.busy); end
    $display("back-to-back pulses at %0d and %0d", p1, p2);
    idle(0);
  endtask

  task automatic test_reset_midframe();
    logic signed [15:0] got;
    for (int b = 0; b < 10; b++)
      drive(0, 1'b1, pack6(1, 0, 0, 0, 0, 0), pack6(1, 0, 0, 0, 0, 0));
    checks++; if (if_def.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", if_def.busy); end
    #2;
    rst_n = 1'b0;
    if_def.run = 1'b0;
    #1;
    checks++; if (if_def.data_out !== '0) begin errors++; $display("FAIL mid_reset_data: got %h expected 0", if_def.data_out); end
    checks++; if (if_def.valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", if_def.valid); end
    checks++; if (if_def.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", if_def.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) idle(0);
    frame(0, pack6(2, 0, 0, 0, 0, 0), pack6(2, 0, 0, 0, 0, 0), '0, '0);
    got = if_def.data_out[15:0];
    checks++; if (if_def.valid !== 1'b1) begin errors++; $display("FAIL mid_after_valid: got %b expected 1", if_def.valid); end
    checks++; if (got !== 16'sd4) begin errors++; $display("FAIL mid_after_slot0: got %0d expected 4", got); end
    checks++; if (if_def.data_out[383:16] !== '0) begin errors++; $display("FAIL mid_after_stale: got %h expected 0", if_def.data_out[383:16]); end
    $display("post-reset frame slot0=%0d", got);
    idle(0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_stall_chunks();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dot_stream_accum.md
Name: dot_stream_accum

Overview:
- Parametrised streaming dot-product engine for the hidden-layer datapath. Successor to the fixed 6-lane/24-output dot block.
- Each accepted beat carries DATA_N signed data/weight lane pairs. CHUNKS beats are reduced into one hidden output, and HID_LENGTH outputs form a frame.
- Results are scaled (FRAC), rounded and saturated to BIT_LENGTH. The complete frame is then published on a double-buffered data_out bus with a one-cycle valid pulse.

Parameters:
- BIT_LENGTH, 16, signed lane/output width (two's complement).
- DATA_N, 6, lanes per beat.
- HID_LENGTH, 24, outputs per frame.
- CHUNKS, 1, beats reduced into one output (>=1).
- FRAC, 0, fractional bits; arithmetic right shift applied to the accumulated sum (0..BIT_LENGTH-1).

Ports:
- clk, input, 1, clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- run, input, 1, beat-valid qualifier: data_in/weight_in are consumed on every rising edge with run=1.
- data_in, input, DATA_N*BIT_LENGTH, lane i = data_in[i*BIT_LENGTH +: BIT_LENGTH], signed.
- weight_in, input, DATA_N*BIT_LENGTH, lane i likewise, signed.
- valid, output, 1, one-cycle pulse: new frame present on data_out.
- busy, output, 1, high while a partially received frame or pipeline contents are in flight.
- data_out, output, HID_LENGTH*BIT_LENGTH, slot h = data_out[h*BIT_LENGTH +: BIT_LENGTH], signed.

Behaviour:
- Reset (async, rst_n=0): all of the following clear to 0 immediately: pipeline regs, beat valid flags, beat_cnt, hid_cnt, working buffer, data_out, valid, busy. Applies mid-frame too; the partial frame is discarded and never published.
- Accept: beat accepted iff run=1 at the edge. There is no backpressure and the block never refuses a beat. run=0 inserts a bubble: counters hold and the bubble propagates down the pipeline.
- Stage 1 (edge of acceptance): DATA_N full-width signed products of 2*BIT_LENGTH registered, together with the beat flag and beat tags (first/last chunk, hid index).
- Stage 2 (+1 edge): adder tree plus accumulator.
  - Accumulator width is 2*BIT_LENGTH + clog2(DATA_N*CHUNKS) + 1 and never overflows.
  - First chunk loads the tree sum; other chunks add to it.
- Stage 3 (+2 edges, last chunk only): scale and write the working-buffer slot[hid].
  - If FRAC>0: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
  - Saturate to [-2^(BIT_LENGTH-1), 2^(BIT_LENGTH-1)-1].
- Counters: beat_cnt wraps 0..CHUNKS-1 per accepted beat. hid_cnt advances on beat_cnt wrap and wraps 0..HID_LENGTH-1.
- Publish: on the edge at which stage 3 writes slot HID_LENGTH-1:
  - the full working buffer (including that slot) is copied to data_out and valid=1 for exactly that cycle;
  - data_out holds otherwise until the next publish.
  - Latency: last accepted beat at edge t gives valid/data_out updated at edge t+2.
- Back-to-back frames: beat 0 of frame n+1 may be accepted on the edge after the last beat of frame n. The working buffer may be overwritten while data_out is stable.
- busy: 1 from the first accepted beat of a frame until the publish edge. It stays 1 across stalls, and stays 1 if a following frame has started.
- X on data lanes with run=0 must not propagate into state.

Test Plan:
- Reset: rst_n=0 at any time, including mid-frame -> data_out=0, valid=0, busy=0 within the same timestep. After 12 idle cycles, one full frame publishes correctly, with no stale slots.
- Basic (defaults): beat 0 data {-9,-8,-5,-1,-5,-3}, weights {5,3,2,9,5,2} (lane0 first), then 23 beats of zero data -> valid one cycle, 2 edges after beat 23. slot0=-119 (0xFF89), slots1..23=0.
- Saturation (FRAC=0): beat 0 all lanes data=weights=32767 -> slot0=32767. All lanes data=-32768, weight=32767 -> slot0=-32768.
- Rounding (FRAC=8): lane0 0x0180*0x0180, others 0 -> 0x0240. Lane0 1*128 -> 1. Lane0 -1*128 -> 0. Lane0 -1*129 -> -1.
- Stall/CHUNKS=2: run low for 3 cycles between beats 5 and 6 -> identical data_out, valid delayed exactly 3 cycles. slot h equals the sum of its two beats' dot products.
- Back-to-back: two frames streamed without gap -> two valid pulses 24 cycles apart. data_out holds frame 1 until the second pulse.
